// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter granting three character blocks 32-byte glyph bursts
// from one of two synchronous font ROMs, selected by the requester's num.
module font_rom_arbiter (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_0,
    input  logic       req_1,
    input  logic       req_2,
    input  logic [3:0] num_0,
    input  logic [3:0] num_1,
    input  logic [3:0] num_2,
    output logic       gnt_0,
    output logic       gnt_1,
    output logic       gnt_2,
    output logic [7:0] data_0,
    output logic [7:0] data_1,
    output logic [7:0] data_2,
    output logic       dvld_0,
    output logic       dvld_1,
    output logic       dvld_2,
    output logic       done_0,
    output logic       done_1,
    output logic       done_2,
    output logic       busy,
    output logic [4:0] rom_2_addr,
    output logic [4:0] rom_3_addr,
    output logic       rom_2_en,
    output logic       rom_3_en,
    input  logic [7:0] rom_2_data,
    input  logic [7:0] rom_3_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] num_q, num_d;

    logic [2:0] req_s;
    logic [1:0] pick_s;
    logic [3:0] num_pick_s;
    logic [2:0] owner_oh_s;
    logic [2:0] gnt_s;
    logic [2:0] dvld_s;
    logic [2:0] done_s;
    logic [7:0] data_sel_s;

    // Scan from the index after the last owner; owner_q doubles as that pointer.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = 2'd0;
        found   = 1'b0;
        idx     = last;
        for (int k = 0; k < 3; k++) begin
            idx = (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
            if (req[idx] && !found) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found = found;
            end
        end
    endfunction

    assign req_s  = {req_2, req_1, req_0};
    assign pick_s = rr_pick(req_s, owner_q);

    // Select the num of the requester that would win arbitration now.
    always_comb begin
        num_pick_s = 4'd0;
        case (pick_s)
            2'd0:    num_pick_s = num_0;
            2'd1:    num_pick_s = num_1;
            2'd2:    num_pick_s = num_2;
            default: num_pick_s = 4'd0;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            owner_q <= 2'd2;
            num_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            num_q   <= num_d;
        end
    end

    // Next-state logic: requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        num_d   = num_q;
        case (state_q)
            IDLE: begin
                if (|req_s) begin
                    owner_d = pick_s;
                    num_d   = num_pick_s;
                    cnt_d   = 5'd0;
                    state_d = BURST;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DRAIN;
                end else begin
                    state_d = BURST;
                end
            end
            DRAIN: begin
                cnt_d   = 5'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 5'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; ROM data arrives one cycle after its address.
    always_comb begin
        owner_oh_s = 3'b000;
        gnt_s      = 3'b000;
        dvld_s     = 3'b000;
        done_s     = 3'b000;
        busy       = 1'b0;
        rom_2_addr = 5'd0;
        rom_3_addr = 5'd0;
        rom_2_en   = 1'b0;
        rom_3_en   = 1'b0;
        data_sel_s = 8'd0;
        case (owner_q)
            2'd0:    owner_oh_s = 3'b001;
            2'd1:    owner_oh_s = 3'b010;
            2'd2:    owner_oh_s = 3'b100;
            default: owner_oh_s = 3'b000;
        endcase
        case (num_q)
            4'd2:    data_sel_s = rom_2_data;
            4'd3:    data_sel_s = rom_3_data;
            default: data_sel_s = 8'd0;
        endcase
        case (state_q)
            BURST: begin
                busy = 1'b1;
                if (cnt_q == 5'd0) begin
                    gnt_s = owner_oh_s;
                end else begin
                    dvld_s = owner_oh_s;
                end
                if (num_q == 4'd2) begin
                    rom_2_addr = cnt_q;
                    rom_2_en   = 1'b1;
                end else if (num_q == 4'd3) begin
                    rom_3_addr = cnt_q;
                    rom_3_en   = 1'b1;
                end else begin
                    rom_2_en = 1'b0;
                end
            end
            DRAIN: begin
                busy   = 1'b1;
                dvld_s = owner_oh_s;
                done_s = owner_oh_s;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign gnt_0  = gnt_s[0];
    assign gnt_1  = gnt_s[1];
    assign gnt_2  = gnt_s[2];
    assign dvld_0 = dvld_s[0];
    assign dvld_1 = dvld_s[1];
    assign dvld_2 = dvld_s[2];
    assign done_0 = done_s[0];
    assign done_1 = done_s[1];
    assign done_2 = done_s[2];
    assign data_0 = dvld_s[0] ? data_sel_s : 8'd0;
    assign data_1 = dvld_s[1] ? data_sel_s : 8'd0;
    assign data_2 = dvld_s[2] ? data_sel_s : 8'd0;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Self-checking bench: directed glyph scenarios plus randomized traffic,
// compared every cycle against a burst-timeline model of the arbiter.
module tb_font_rom_arbiter;

    logic       clk;
    logic       rstn;
    logic [2:0] req;
    logic [3:0] num [3];
    logic       gnt_0, gnt_1, gnt_2, dvld_0, dvld_1, dvld_2, done_0, done_1, done_2, busy;
    logic [7:0] data_0, data_1, data_2;
    logic [4:0] rom_2_addr, rom_3_addr;
    logic       rom_2_en, rom_3_en;
    logic [7:0] rom_2_data, rom_3_data;

    logic [7:0] rom2 [32];
    logic [7:0] rom3 [32];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // model: m_t = -1 idle, else cycles since the grant cycle (0..32)
    int m_t    = -1;
    int m_last = 2;
    int m_owner = 0;
    int m_num  = 0;

    int gnt_cnt [3];
    int dvld_cnt [3];
    int done_cnt [3];
    int en2_cnt, en3_cnt, busy_cnt;
    int gnt_idx_q [$];
    int gnt_cyc_q [$];
    logic [7:0] data_q [$];

    font_rom_arbiter dut (
        .clk(clk), .rstn(rstn),
        .req_0(req[0]), .req_1(req[1]), .req_2(req[2]),
        .num_0(num[0]), .num_1(num[1]), .num_2(num[2]),
        .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2),
        .data_0(data_0), .data_1(data_1), .data_2(data_2),
        .dvld_0(dvld_0), .dvld_1(dvld_1), .dvld_2(dvld_2),
        .done_0(done_0), .done_1(done_1), .done_2(done_2),
        .busy(busy),
        .rom_2_addr(rom_2_addr), .rom_3_addr(rom_3_addr),
        .rom_2_en(rom_2_en), .rom_3_en(rom_3_en),
        .rom_2_data(rom_2_data), .rom_3_data(rom_3_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous ROMs; output is junk whenever not enabled
    always @(posedge clk) begin
        rom_2_data <= rom_2_en ? rom2[rom_2_addr] : 8'($urandom);
        rom_3_data <= rom_3_en ? rom3[rom_3_addr] : 8'($urandom);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) begin
            gnt_cnt[i] = 0; dvld_cnt[i] = 0; done_cnt[i] = 0;
        end
        en2_cnt = 0; en3_cnt = 0; busy_cnt = 0;
        gnt_idx_q.delete(); gnt_cyc_q.delete(); data_q.delete();
    endtask

    // advance the model across the coming edge using the inputs now driven
    task automatic model_next();
        if (!rstn) begin
            m_t = -1;
            m_last = 2;
        end else if (m_t < 0) begin
            for (int k = 1; k <= 3; k++) begin
                int i;
                i = (m_last + k) % 3;
                if (m_t < 0 && req[i]) begin
                    m_owner = i;
                    m_last  = i;
                    m_num   = int'(num[i]);
                    m_t     = 0;
                end
            end
        end else if (m_t == 32) begin
            m_t = -1;
        end else begin
            m_t++;
        end
    endtask

    task automatic check_outputs();
        logic [2:0] e_gnt, e_dvld, e_done, a_gnt, a_dvld, a_done;
        logic [23:0] e_data, a_data;
        logic [5:0] e_r2, e_r3;
        logic [7:0] byte_v;
        e_gnt = 3'b000; e_dvld = 3'b000; e_done = 3'b000; e_data = 24'd0;
        e_r2 = 6'd0; e_r3 = 6'd0;
        if (m_t >= 0) begin
            e_gnt[m_owner]  = (m_t == 0);
            e_dvld[m_owner] = (m_t >= 1);
            e_done[m_owner] = (m_t == 32);
            if (m_t <= 31 && m_num == 2) e_r2 = {1'b1, 5'(m_t)};
            if (m_t <= 31 && m_num == 3) e_r3 = {1'b1, 5'(m_t)};
            if (m_t >= 1) begin
                byte_v = (m_num == 2) ? rom2[m_t-1] : (m_num == 3) ? rom3[m_t-1] : 8'h00;
                e_data[m_owner*8 +: 8] = byte_v;
            end
        end
        a_gnt  = {gnt_2, gnt_1, gnt_0};
        a_dvld = {dvld_2, dvld_1, dvld_0};
        a_done = {done_2, done_1, done_0};
        a_data = {data_2, data_1, data_0};
        chk("gnt", 64'(a_gnt), 64'(e_gnt));
        chk("dvld", 64'(a_dvld), 64'(e_dvld));
        chk("done", 64'(a_done), 64'(e_done));
        chk("data", 64'(a_data), 64'(e_data));
        chk("busy", 64'(busy), 64'(m_t >= 0));
        chk("rom2", 64'({rom_2_en, rom_2_addr}), 64'(e_r2));
        chk("rom3", 64'({rom_3_en, rom_3_addr}), 64'(e_r3));
        chk("onehot", 64'(($countones(a_gnt) <= 1) && ($countones(a_dvld) <= 1)
                          && ($countones(a_done) <= 1)), 64'd1);
        for (int i = 0; i < 3; i++) begin
            if (a_gnt[i]) begin
                gnt_cnt[i]++; gnt_idx_q.push_back(i); gnt_cyc_q.push_back(cyc);
            end
            if (a_dvld[i]) begin
                dvld_cnt[i]++; data_q.push_back(a_data[i*8 +: 8]);
            end
            if (a_done[i]) done_cnt[i]++;
        end
        if (rom_2_en) en2_cnt++;
        if (rom_3_en) en3_cnt++;
        if (busy) busy_cnt++;
    endtask

    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    // run until all requesters are idle; each drops req once granted
    task automatic run_drop(input int n);
        for (int s = 0; s < n; s++) begin
            step();
            if (gnt_0) req[0] = 1'b0;
            if (gnt_1) req[1] = 1'b0;
            if (gnt_2) req[2] = 1'b0;
        end
    endtask

    task automatic wait_gnt(input int idx, input int limit);
        int seen;
        seen = 0;
        for (int s = 0; s < limit && seen == 0; s++) begin
            step();
            if ({gnt_2, gnt_1, gnt_0} == (3'b001 << idx)) seen = 1;
        end
        chk("gnt_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        logic [7:0] all_zero;
        for (int k = 0; k < 32; k++) begin
            rom2[k] = 8'(k + 8'h40);
            rom3[k] = 8'($urandom);
        end
        rstn = 1'b0; req = 3'b000;
        for (int i = 0; i < 3; i++) num[i] = 4'd0;
        clear_stats();
        step(); step();
        chk("reset_outs", 64'({gnt_2, gnt_1, gnt_0, dvld_2, dvld_1, dvld_0, done_2, done_1,
                              done_0, busy, rom_2_en, rom_3_en, rom_2_addr, rom_3_addr,
                              data_0, data_1, data_2}), 64'd0);
        rstn = 1'b1;
        step();

        // single request on ROM 2
        clear_stats();
        req[1] = 1'b1; num[1] = 4'd2;
        run_drop(40);
        chk("s_gnt1", 64'(gnt_cnt[1]), 64'd1);
        chk("s_dvld1", 64'(dvld_cnt[1]), 64'd32);
        chk("s_done1", 64'(done_cnt[1]), 64'd1);
        chk("s_en2", 64'(en2_cnt), 64'd32);
        chk("s_en3", 64'(en3_cnt), 64'd0);
        chk("s_busy", 64'(busy_cnt), 64'd33);
        for (int k = 0; k < 32; k++) begin
            if (k < data_q.size()) chk("s_byte", 64'(data_q[k]), 64'(k + 8'h40));
        end

        // contention from reset
        rstn = 1'b0; req = 3'b111; num[0] = 4'd2; num[1] = 4'd3; num[2] = 4'd2;
        step();
        rstn = 1'b1;
        clear_stats();
        for (int s = 0; s < 140; s++) step();
        chk("c_ngnt", 64'(gnt_idx_q.size() >= 4), 64'd1);
        if (gnt_idx_q.size() >= 4) begin
            chk("c_ord0", 64'(gnt_idx_q[0]), 64'd0);
            chk("c_ord1", 64'(gnt_idx_q[1]), 64'd1);
            chk("c_ord2", 64'(gnt_idx_q[2]), 64'd2);
            chk("c_ord3", 64'(gnt_idx_q[3]), 64'd0);
            chk("c_gap1", 64'(gnt_cyc_q[1] - gnt_cyc_q[0]), 64'd34);
            chk("c_gap3", 64'(gnt_cyc_q[3] - gnt_cyc_q[2]), 64'd34);
        end
        req = 3'b000;
        for (int s = 0; s < 40; s++) step();

        // invalid select
        clear_stats();
        req[2] = 1'b1; num[2] = 4'd5;
        run_drop(40);
        chk("i_dvld2", 64'(dvld_cnt[2]), 64'd32);
        chk("i_done2", 64'(done_cnt[2]), 64'd1);
        chk("i_en", 64'(en2_cnt + en3_cnt), 64'd0);
        all_zero = 8'd0;
        foreach (data_q[k]) all_zero = all_zero | data_q[k];
        chk("i_data", 64'(all_zero), 64'd0);

        // mid-burst input changes
        clear_stats();
        req[0] = 1'b1; num[0] = 4'd3;
        wait_gnt(0, 10);
        for (int s = 0; s < 10; s++) step();
        chk("m_byte10", 64'({rom_3_en, rom_3_addr}), 64'({1'b1, 5'd10}));
        req[0] = 1'b0; num[0] = 4'd2;
        for (int s = 0; s < 30; s++) step();
        chk("m_en3", 64'(en3_cnt), 64'd32);
        chk("m_en2", 64'(en2_cnt), 64'd0);
        chk("m_gnt0", 64'(gnt_cnt[0]), 64'd1);

        // reset mid-burst of owner 1, then 1 and 2 contend
        req[1] = 1'b1; num[1] = 4'd3;
        wait_gnt(1, 10);
        req[1] = 1'b0;
        for (int s = 0; s < 15; s++) step();
        clear_stats();
        rstn = 1'b0; req[1] = 1'b1; req[2] = 1'b1; num[2] = 4'd2;
        step();
        chk("r_outs", 64'({gnt_2, gnt_1, gnt_0, dvld_2, dvld_1, dvld_0, done_2, done_1,
                          done_0, busy, rom_2_en, rom_3_en, rom_2_addr, rom_3_addr,
                          data_0, data_1, data_2}), 64'd0);
        rstn = 1'b1;
        step();
        chk("r_first", 64'({gnt_2, gnt_1, gnt_0}), 64'b010);
        chk("r_done", 64'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 64'd0);
        req = 3'b000;
        for (int s = 0; s < 80; s++) step();

        // randomized traffic with occasional resets
        for (int s = 0; s < 4000; s++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = 1'($urandom);
                if ($urandom_range(0, 7) == 0)
                    num[i] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(2, 3));
            end
            rstn = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
